// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared widths and FSM state type for the data-memory path
package riscv_mem_pkg;
  localparam int XLEN = 32;
  localparam int BE_W = 4;
  localparam int LAT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word array with per-byte write enables and registered read
module dmem_array
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [BE_W-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-outstanding load/store responder with fixed response latency
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int              LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [XLEN:0] LIMIT = {1'b0, BASE_ADDR} + (XLEN+1)'(4 * DEPTH_WORDS);
  state_t state, state_nx;
  logic [LAT_W-1:0] cnt;
  logic [AW-1:0] idx, idx_q, addr;
  logic [XLEN-1:0] q;
  logic accept, err, err_q, zero_q;
  // BASE_ADDR is aligned to the array size, so the index needs only the low address bits
  assign idx = req_addr[AW+1:2] - BASE_ADDR[AW+1:2];
  assign err = (|req_addr[1:0]) || (req_addr < BASE_ADDR) || ({1'b0, req_addr} >= LIMIT);
  assign accept = req_valid && req_ready;
  // In IDLE the array tracks the incoming address so the read lands on the acceptance edge
  assign addr = (state == IDLE) ? idx : idx_q;
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk,
    .we(accept && req_write && !err),
    .be(req_be),
    .addr,
    .wdata(req_wdata),
    .rdata(q)
  );
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (accept ? ((LATENCY == 1) ? RESP : WAIT) : IDLE) :
               (state == WAIT) ? ((cnt == LAT_W'(1)) ? RESP : WAIT) :
               (rsp_ready ? IDLE : RESP);
  always_comb begin
    req_ready = (state == IDLE) && !reset;
    rsp_valid = (state == RESP);
    rsp_rdata = (rsp_valid && !zero_q) ? q : '0;
    rsp_err = rsp_valid && err_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      err_q <= 1'b0;
      zero_q <= 1'b0;
      idx_q <= '0;
    end else if (accept) begin
      cnt <= LAT_W'(LATENCY - 1);
      err_q <= err;
      zero_q <= err || req_write;
      idx_q <= idx;
    end else if (state == WAIT) begin
      cnt <= cnt - 1'b1;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks on three responders (latency 2, 4 and 1)
module tb_dmem_responder;
  import riscv_mem_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] req_valid = '0;
  logic [2:0] rsp_ready = '0;
  logic [2:0] req_ready, rsp_valid, rsp_err;
  logic req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0] req_be = '0;
  logic [31:0] rsp_rdata [3];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2)) u0 (
    .clk, .reset, .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write, .req_addr,
    .req_wdata, .req_be, .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
  dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h1000), .LATENCY(4)) u1 (
    .clk, .reset, .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write, .req_addr,
    .req_wdata, .req_be, .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1)) u2 (
    .clk, .reset, .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write, .req_addr,
    .req_wdata, .req_be, .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  // n returns cycles between acceptance and rsp_valid (LATENCY-1); 99 if never accepted
  task automatic do_req(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output logic er, output int n);
    req_write = w;
    req_addr = a;
    req_wdata = d;
    req_be = b;
    req_valid[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready[k]) begin
      req_valid[k] = 1'b0;
      rd = 'x;
      er = 1'bx;
      n = 99;
      return;
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    n = 0;
    while (!rsp_valid[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    rd = rsp_rdata[k];
    er = rsp_err[k];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 3'b000 || rsp_valid !== 3'b000 || rsp_err !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b valid=%b err=%b, required 000 000 000", req_ready, rsp_valid, rsp_err);
    end
    checks++;
    if ((rsp_rdata[0] | rsp_rdata[1] | rsp_rdata[2]) !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h %h %h, required 0", rsp_rdata[0], rsp_rdata[1], rsp_rdata[2]);
    end
    reset = 1'b0;
    rsp_ready = 3'b111;
    #1;
    checks++;
    if (req_ready !== 3'b111) begin
      failures++;
      $display("FAIL ready_after_reset: got %b, required 111", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic er;
    int n;
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, n);
    checks++;
    if (n !== 1 || er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL store_rsp: lat=%0d err=%b rdata=%h, required 1 0 00000000", n, er, rd);
    end
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, n);
    checks++;
    if (n !== 1 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_rsp: lat=%0d err=%b rdata=%h, required 1 0 deadbeef", n, er, rd);
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd;
    logic er;
    int n;
    do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, n);
    do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, n);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, n);
    checks++;
    if (rd !== 32'h11BB33DD || er !== 1'b0) begin
      failures++;
      $display("FAIL partial_store: rdata=%h err=%b, required 11bb33dd 0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic er;
    int n;
    do_req(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, n);
    do_req(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er, n);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL misaligned_load: err=%b rdata=%h, required 1 00000000", er, rd);
    end
    do_req(0, 1'b1, 32'h1000, 32'h55555555, 4'hF, rd, er, n);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL range_store: err=%b rdata=%h, required 1 00000000", er, rd);
    end
    do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, n);
    checks++;
    if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL word0_intact: err=%b rdata=%h, required 0 cafef00d", er, rd);
    end
    do_req(1, 1'b0, 32'h0FFC, 32'h0, 4'h0, rd, er, n);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || n !== 3) begin
      failures++;
      $display("FAIL below_base: err=%b rdata=%h lat=%0d, required 1 00000000 3", er, rd, n);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] rd;
    logic er;
    int n;
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, n);
    req_write = 1'b1;
    req_addr = 32'h10;
    req_wdata = 32'h0;
    req_be = 4'hF;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid[0], req_ready[0], rsp_rdata[0]} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
        failures++;
        $display("FAIL hold_%0d: valid=%b ready=%b rdata=%h, required 1 0 deadbeef",
                 i, rsp_valid[0], req_ready[0], rsp_rdata[0]);
      end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL release: ready=%b valid=%b, required 1 0", req_ready[0], rsp_valid[0]);
    end
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, n);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL blocked_store_ignored: rdata=%h, required deadbeef", rd);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    logic er;
    int n;
    bit seen;
    req_write = 1'b1;
    req_addr = 32'h1040;
    req_wdata = 32'h5A5A5A5A;
    req_be = 4'hF;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
      failures++;
      $display("FAIL in_reset: ready=%b valid=%b, required 0 0", req_ready[1], rsp_valid[1]);
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid[1]) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL dropped_rsp: rsp_valid seen=%b, required 0", seen);
    end
    do_req(1, 1'b0, 32'h1040, 32'h0, 4'h0, rd, er, n);
    checks++;
    if (rd !== 32'h5A5A5A5A || er !== 1'b0 || n !== 3) begin
      failures++;
      $display("FAIL store_survives: rdata=%h err=%b lat=%0d, required 5a5a5a5a 0 3", rd, er, n);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic er;
    int n;
    do_req(2, 1'b1, 32'h100, 32'h0A0B0C0D, 4'hF, rd, er, n);
    checks++;
    if (n !== 0 || er !== 1'b0) begin
      failures++;
      $display("FAIL lat1_store: lat=%0d err=%b, required 0 0", n, er);
    end
    do_req(2, 1'b1, 32'h104, 32'h01020304, 4'hF, rd, er, n);
    req_write = 1'b0;
    req_addr = 32'h100;
    req_valid[2] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid[2], req_ready[2], rsp_rdata[2]} !== {1'b1, 1'b0, 32'h0A0B0C0D}) begin
      failures++;
      $display("FAIL b2b_first: valid=%b ready=%b rdata=%h, required 1 0 0a0b0c0d",
               rsp_valid[2], req_ready[2], rsp_rdata[2]);
    end
    req_addr = 32'h104;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap: valid=%b ready=%b, required 0 1", rsp_valid[2], req_ready[2]);
    end
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    checks++;
    if (rsp_valid[2] !== 1'b1 || rsp_rdata[2] !== 32'h01020304) begin
      failures++;
      $display("FAIL b2b_second: valid=%b rdata=%h, required 1 01020304", rsp_valid[2], rsp_rdata[2]);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid[2] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done: valid=%b, required 0", rsp_valid[2]);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_partial_store();
    test_errors();
    test_back_pressure();
    test_reset_mid_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
